// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and flag-register layout.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_INC  = 4'h8;
  localparam logic [3:0] OP_DEC  = 4'h9;
  localparam logic [3:0] OP_ADC  = 4'hA;
  localparam logic [3:0] OP_SBB  = 4'hB;
  localparam logic [3:0] OP_CMP  = 4'hC;
  localparam logic [3:0] OP_MUL  = 4'hD;
  localparam logic [3:0] OP_PASS = 4'hE;
  localparam logic [3:0] OP_NOP  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Flag register bit positions
  localparam int FLAG_P    = 0;
  localparam int FLAG_S    = 1;
  localparam int FLAG_Z    = 2;
  localparam int FLAG_C    = 3;
  localparam int FLAG_AC   = 4;
  localparam int NUM_FLAGS = 5;

endpackage

// File: rtl/alu_mul_seq.sv
// WIDTH-cycle shift-add unsigned multiplier; start loads operands, done pulses one cycle
// after the last partial-product step with prod holding the full 2*WIDTH-bit product.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH:0]   sum;

  // Upper half accumulates the multiplicand whenever the current multiplier LSB is set;
  // the multiplier itself sits in the lower half and shifts out as the product shifts in.
  always_comb begin
    sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  end

  assign busy = (count != '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation results.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      done  <= 1'b0;
      mcand <= '0;
      prod  <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        mcand <= a;
        prod  <= {{WIDTH{1'b0}}, b};
        count <= CW'(WIDTH);
      end else if (busy) begin
        prod  <= {sum, prod[WIDTH-1:1]};
        count <= count - CW'(1);
        done  <= (count == CW'(1));
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with sticky flags, carry-in ops, sequential multiplier and a
// valid/ready handshake on both sides; one operation in flight at a time.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ac,
  output logic             c,
  output logic             z,
  output logic             s,
  output logic             p
);

  state_t                 state, state_nx;
  logic [NUM_FLAGS-1:0]   flags;
  logic                   accept;
  logic                   mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0]     mul_prod;

  assign in_ready  = (state == ST_IDLE) && !mul_busy;
  assign out_valid = (state == ST_HOLD);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (sel == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (a),
    .b     (b),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // NOTE: every variable driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = (sel == OP_MUL) ? ST_MUL : ST_HOLD;
      ST_MUL:  if (mul_done) state_nx = ST_HOLD;
      ST_HOLD: if (out_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Single-cycle datapath
  logic [WIDTH:0]         wide;
  logic [WIDTH-1:0]       r;
  logic                   cy, acy, upd_out, upd_flags;
  logic [WIDTH:0]         cin;
  logic [NUM_FLAGS-1:0]   alu_flags, mul_flags;
  logic [WIDTH-1:0]       mul_lo, mul_hi;

  assign cin    = (WIDTH+1)'(flags[FLAG_C]);
  assign mul_lo = mul_prod[WIDTH-1:0];
  assign mul_hi = mul_prod[2*WIDTH-1:WIDTH];

  always_comb begin
    wide      = '0;
    r         = '0;
    cy        = 1'b0;
    acy       = 1'b0;
    upd_out   = 1'b1;
    upd_flags = 1'b1;
    case (sel)
      OP_ADD, OP_ADC: begin
        wide = {1'b0, a} + {1'b0, b} + ((sel == OP_ADC) ? cin : '0);
        r    = wide[WIDTH-1:0];
        cy   = wide[WIDTH];
        acy  = a[4] ^ b[4] ^ r[4];  // carry into bit 4 recovered from the sum bit
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        wide    = {1'b0, a} - {1'b0, b} - ((sel == OP_SBB) ? cin : '0);
        r       = wide[WIDTH-1:0];
        cy      = wide[WIDTH];
        acy     = a[4] ^ b[4] ^ r[4];
        upd_out = (sel != OP_CMP);
      end
      OP_INC, OP_DEC: begin
        wide = (sel == OP_INC) ? ({1'b0, a} + (WIDTH+1)'(1)) : ({1'b0, a} - (WIDTH+1)'(1));
        r    = wide[WIDTH-1:0];
        cy   = wide[WIDTH];
        acy  = a[4] ^ r[4];
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_PASS: r = b;
      OP_SHL: begin
        r  = {a[WIDTH-2:0], 1'b0};
        cy = a[WIDTH-1];
      end
      OP_SHR: begin
        r  = {1'b0, a[WIDTH-1:1]};
        cy = a[0];
      end
      default: begin  // MUL completes later; NOP changes nothing
        upd_out   = 1'b0;
        upd_flags = 1'b0;
      end
    endcase

    alu_flags          = '0;
    alu_flags[FLAG_AC] = acy;
    alu_flags[FLAG_C]  = cy;
    alu_flags[FLAG_Z]  = (r == '0);
    alu_flags[FLAG_S]  = r[WIDTH-1];
    alu_flags[FLAG_P]  = ~^r;

    mul_flags          = '0;
    mul_flags[FLAG_C]  = (mul_hi != '0);
    mul_flags[FLAG_Z]  = (mul_lo == '0);
    mul_flags[FLAG_S]  = mul_lo[WIDTH-1];
    mul_flags[FLAG_P]  = ~^mul_lo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out    <= '0;
      out_hi <= '0;
      flags  <= '0;
    end else if (accept && (sel != OP_MUL)) begin
      if (upd_out)   out   <= r;
      if (upd_flags) flags <= alu_flags;
      out_hi <= '0;
    end else if ((state == ST_MUL) && mul_done) begin
      out    <= mul_lo;
      out_hi <= mul_hi;
      flags  <= mul_flags;
    end
  end

  assign ac = flags[FLAG_AC];
  assign c  = flags[FLAG_C];
  assign z  = flags[FLAG_Z];
  assign s  = flags[FLAG_S];
  assign p  = flags[FLAG_P];

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed steps plus random ops checked
// against an arithmetic reference model of the opcode and flag rules.
module tb_alu_seq;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, out, out_hi;
  logic [3:0] sel;
  logic       ac, c, z, s, p;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_out, m_hi;
  logic [4:0] m_fl;  // {ac, c, z, s, p}

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_hi    (out_hi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ac        (ac),
    .c         (c),
    .z         (z),
    .s         (s),
    .p         (p)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode rules.
  task automatic model(input logic [7:0] ta, input logic [7:0] tb_, input logic [3:0] op);
    int x, y, cin, r, prodv, hi;
    bit cy, acy;
    logic [7:0] lo;
    x = int'(ta); y = int'(tb_); cin = int'(m_fl[3]);
    r = 0; hi = 0; cy = 0; acy = 0;
    if (op == OP_NOP) begin
      m_hi = 8'h00;
      return;
    end
    case (op)
      OP_ADD:  begin r = x + y;       cy = (r > 255); acy = ((x % 16) + (y % 16)) > 15; end
      OP_ADC:  begin r = x + y + cin; cy = (r > 255); acy = ((x % 16) + (y % 16) + cin) > 15; end
      OP_SUB, OP_CMP:
               begin r = x - y;       cy = (x < y);   acy = (x % 16) < (y % 16); end
      OP_SBB:  begin r = x - y - cin; cy = (x < y + cin); acy = (x % 16) < ((y % 16) + cin); end
      OP_INC:  begin r = x + 1;       cy = (x == 255); acy = ((x % 16) == 15); end
      OP_DEC:  begin r = x - 1;       cy = (x == 0);   acy = ((x % 16) == 0); end
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_NOT:  r = 255 - x;
      OP_PASS: r = y;
      OP_SHL:  begin r = x * 2; cy = (x >= 128); end
      OP_SHR:  begin r = x / 2; cy = (x % 2) == 1; end
      OP_MUL:  begin prodv = x * y; r = prodv % 256; hi = prodv / 256; cy = (hi != 0); end
      default: r = 0;
    endcase
    lo   = 8'(r & 255);
    m_fl = {acy, cy, (lo == 8'h00), (lo >= 8'h80), (($countones(lo) % 2) == 0)};
    if (op != OP_CMP) m_out = lo;
    m_hi = 8'(hi);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out"},       32'(out), 32'(m_out));
    check({tag, "_out_hi"},    32'(out_hi), 0);
    check({tag, "_flags"},     32'({ac, c, z, s, p}), 0);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_in_ready"},  32'(in_ready), 1);
  endtask

  // Issue one op from IDLE, check latency/result, hold for 'hold' cycles, then release.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic [3:0] op,
                        input int hold);
    int n;
    int exp_lat;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check("in_ready_before_issue", 32'(in_ready), 1);
    a = ta; b = tb_; sel = op; in_valid = 1'b1;
    model(ta, tb_, op);
    exp_lat = (op == OP_MUL) ? 9 : 0;
    @(negedge clk);
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); sel = 4'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      check("in_ready_while_busy", 32'(in_ready), 0);
      @(negedge clk);
      n++;
    end
    check($sformatf("latency_op%0h", op), 32'(n), 32'(exp_lat));
    check($sformatf("out_op%0h", op),     32'(out), 32'(m_out));
    check($sformatf("out_hi_op%0h", op),  32'(out_hi), 32'(m_hi));
    check($sformatf("flags_op%0h", op),   32'({ac, c, z, s, p}), 32'(m_fl));
    repeat (hold) begin
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); sel = 4'($urandom);
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 1);
      check("hold_in_ready",  32'(in_ready), 0);
      check("hold_out",       32'(out), 32'(m_out));
      check("hold_flags",     32'({ac, c, z, s, p}), 32'(m_fl));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_in_ready",  32'(in_ready), 1);
    check("release_out_valid", 32'(out_valid), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'h00; b = 8'h00; sel = 4'h0;
    m_out = 8'h00; m_hi = 8'h00; m_fl = 5'b0;

    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed arithmetic and flag cases
    run_op(8'h0A, 8'h8F, OP_ADD, 0);
    check("add_exact_out", 32'(out), 32'h99);
    run_op(8'h0A, 8'h8F, OP_SUB, 0);
    check("sub_exact_out", 32'(out), 32'h7B);
    run_op(8'h01, 8'h01, OP_ADC, 0);
    check("adc_exact_out", 32'(out), 32'h03);
    run_op(8'h0A, 8'h8F, OP_MUL, 5);
    check("mul_exact_hi", 32'(out_hi), 32'h05);
    run_op(8'h81, 8'h00, OP_SHL, 1);
    run_op(8'h01, 8'h00, OP_SHR, 0);
    run_op(8'h00, 8'h00, OP_DEC, 0);
    run_op(8'h20, 8'h05, OP_SBB, 0);
    run_op(8'h10, 8'h20, OP_CMP, 2);
    run_op(8'h3C, 8'h00, OP_NOP, 0);
    run_op(8'hFF, 8'hFF, OP_MUL, 0);
    run_op(8'h00, 8'h5A, OP_PASS, 0);

    // Abort a multiply partway through; no result may appear afterwards.
    a = 8'h0A; b = 8'h8F; sel = OP_MUL; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_out = 8'h00; m_hi = 8'h00; m_fl = 5'b0;
    check_reset_state("abort");
    repeat (12) begin
      @(negedge clk);
      check("abort_no_out_valid", 32'(out_valid), 0);
    end

    // Reset wins over a simultaneous request.
    rst = 1'b1; in_valid = 1'b1; a = 8'h11; b = 8'h22; sel = OP_ADD;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check_reset_state("rst_priority");

    run_op(8'hFF, 8'h00, OP_INC, 0);
    check("inc_wrap_out", 32'(out), 32'h00);

    // Randomized ops against the model
    for (int i = 0; i < 60; i++) begin
      run_op(8'($urandom), 8'($urandom), 4'($urandom), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
